// File: rtl/rolhas_pkg.sv
// rolhas_pkg
// Shared definitions for the cork (rolha) transfer link: the transmitter
// state encoding and the default sizing constants. The receiver and the
// display codifiers import the same package.
package rolhas_pkg;

  // Transmitter states. ST_ERR is only reachable when the handshake
  // timeout option (ROLHAS_TX_TIMEOUT_EN) is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_REQ     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ERR     = 3'd4
  } rolhas_state_t;

  localparam int ROLHAS_WIDTH     = 7;   // width of every cork count
  localparam int ROLHAS_CAPACITY  = 99;  // principal reservoir capacity
  localparam int ROLHAS_MAX_BATCH = 15;  // corks moved per handshake, max

endpackage

// File: rtl/rolhas_transfer_tx_if.sv
// rolhas_transfer_tx_if
// Bundles the reservoir status inputs and the req/ack transfer bus of the
// cork transfer transmitter.
//   enable, min_r        : line run and principal-minimum flags
//   sec_count, pri_count : secondary / principal reservoir counts
//   ack                  : receiver acknowledge
//   req, rolhas_transfer : request and batch size (valid while req=1)
//   sec_dec              : one-cycle "subtract batch from secondary" pulse
//   busy, tx_err         : status (non-idle, sticky handshake timeout)
// Modports: master = transmitter side, slave = environment/receiver side.
interface rolhas_transfer_tx_if
  import rolhas_pkg::*;
#(
  parameter int WIDTH = ROLHAS_WIDTH
);
  logic             enable;
  logic             min_r;
  logic [WIDTH-1:0] sec_count;
  logic [WIDTH-1:0] pri_count;
  logic             ack;
  logic             req;
  logic [WIDTH-1:0] rolhas_transfer;
  logic             sec_dec;
  logic             busy;
  logic             tx_err;

  modport master (
    input  enable, min_r, sec_count, pri_count, ack,
    output req, rolhas_transfer, sec_dec, busy, tx_err
  );

  modport slave (
    output enable, min_r, sec_count, pri_count, ack,
    input  req, rolhas_transfer, sec_dec, busy, tx_err
  );
endinterface

// File: rtl/rolhas_calc_lote.sv
// rolhas_calc_lote
// Combinational batch-size calculation:
//   lote = min(sec_count, CAPACITY - pri_count, MAX_BATCH)
// The free-room term saturates at 0 when the principal reservoir is at or
// above capacity, and every intermediate stays WIDTH bits wide.
// Ports:
//   sec_count (in, WIDTH) : secondary reservoir count
//   pri_count (in, WIDTH) : principal reservoir count
//   lote      (out, WIDTH): batch size to move
module rolhas_calc_lote
  import rolhas_pkg::*;
#(
  parameter int WIDTH     = ROLHAS_WIDTH,
  parameter int CAPACITY  = ROLHAS_CAPACITY,
  parameter int MAX_BATCH = ROLHAS_MAX_BATCH
) (
  input  logic [WIDTH-1:0] sec_count,
  input  logic [WIDTH-1:0] pri_count,
  output logic [WIDTH-1:0] lote
);

  localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_BATCH);

  logic [WIDTH-1:0] room;
  logic [WIDTH-1:0] min_sr;

  always_comb begin
    room   = (pri_count >= CAP_W) ? '0 : (CAP_W - pri_count);
    min_sr = (sec_count < room) ? sec_count : room;
    lote   = (min_sr < MAX_W) ? min_sr : MAX_W;
  end

endmodule

// File: rtl/rolhas_transfer_tx.sv
// rolhas_transfer_tx
// Transmitter of the cork transfer link (secondary -> principal reservoir).
// When the principal reservoir reports minimum level it computes a batch in
// a one-cycle LOAD state, presents it under a four-phase req/ack handshake,
// and on acknowledge pulses sec_dec for one cycle so the secondary register
// subtracts the batch. All outputs are registered.
// Ports:
//   clk : divided system clock, rising edge
//   clr : asynchronous active-low reset
//   bus : rolhas_transfer_tx_if.master (status inputs, req/ack bus, flags)
// Optional build macro ROLHAS_TX_TIMEOUT_EN: adds a cycle counter over the
// REQ and RELEASE states; reaching TIMEOUT_CYC enters ST_ERR and sets the
// sticky tx_err flag. Without it the block waits indefinitely for ack and
// tx_err is constant 0.
module rolhas_transfer_tx
  import rolhas_pkg::*;
#(
  parameter int WIDTH       = ROLHAS_WIDTH,
  parameter int CAPACITY    = ROLHAS_CAPACITY,
`ifdef ROLHAS_TX_TIMEOUT_EN
  parameter int MAX_BATCH   = ROLHAS_MAX_BATCH,
  parameter int TIMEOUT_CYC = 255
`else
  parameter int MAX_BATCH   = ROLHAS_MAX_BATCH
`endif
) (
  input  logic                  clk,
  input  logic                  clr,
  rolhas_transfer_tx_if.master  bus
);

  rolhas_state_t    state_reg;
  logic             req_reg;
  logic             sec_dec_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] xfer_reg;
  logic [WIDTH-1:0] lote;

`ifdef ROLHAS_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_reg;
  logic             tx_err_reg;
`endif

  rolhas_calc_lote #(
    .WIDTH     (WIDTH),
    .CAPACITY  (CAPACITY),
    .MAX_BATCH (MAX_BATCH)
  ) u_calc_lote (
    .sec_count (bus.sec_count),
    .pri_count (bus.pri_count),
    .lote      (lote)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg   <= ST_IDLE;
      req_reg     <= 1'b0;
      sec_dec_reg <= 1'b0;
      busy_reg    <= 1'b0;
      xfer_reg    <= '0;
`ifdef ROLHAS_TX_TIMEOUT_EN
      tmo_cnt_reg <= '0;
      tx_err_reg  <= 1'b0;
`endif
    end else begin
      // sec_dec is a single-cycle pulse; only the REQ->RELEASE step sets it.
      sec_dec_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A stale ack (still high from a previous exchange) blocks start.
          if (bus.enable && bus.min_r && (bus.sec_count != '0) && !bus.ack) begin
            state_reg <= ST_LOAD;
            busy_reg  <= 1'b1;
          end
        end

        ST_LOAD: begin
          if ((lote == '0) || !bus.enable) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= ST_REQ;
            req_reg   <= 1'b1;
            xfer_reg  <= lote;
`ifdef ROLHAS_TX_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
          end
        end

        ST_REQ: begin
          // ack has priority over a simultaneous enable drop: the batch commits.
          if (bus.ack) begin
            state_reg   <= ST_RELEASE;
            req_reg     <= 1'b0;
            sec_dec_reg <= 1'b1;
`ifdef ROLHAS_TX_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
          end else if (!bus.enable) begin
            state_reg <= ST_IDLE;
            req_reg   <= 1'b0;
            xfer_reg  <= '0;
            busy_reg  <= 1'b0;
          end
`ifdef ROLHAS_TX_TIMEOUT_EN
          else if (tmo_cnt_reg == CNT_LAST) begin
            state_reg  <= ST_ERR;
            req_reg    <= 1'b0;
            xfer_reg   <= '0;
            tx_err_reg <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end

        ST_RELEASE: begin
          // enable is ignored here: the batch was already committed.
          if (!bus.ack) begin
            state_reg <= ST_IDLE;
            xfer_reg  <= '0;
            busy_reg  <= 1'b0;
          end
`ifdef ROLHAS_TX_TIMEOUT_EN
          else if (tmo_cnt_reg == CNT_LAST) begin
            state_reg  <= ST_ERR;
            xfer_reg   <= '0;
            tx_err_reg <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end

`ifdef ROLHAS_TX_TIMEOUT_EN
        ST_ERR: begin
          // Leave only once the line is stopped and the receiver is quiet;
          // tx_err itself is cleared by clr alone.
          if (!bus.enable && !bus.ack) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
`endif

        default: begin
          state_reg <= ST_IDLE;
          req_reg   <= 1'b0;
          xfer_reg  <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req             = req_reg;
  assign bus.rolhas_transfer = xfer_reg;
  assign bus.sec_dec         = sec_dec_reg;
  assign bus.busy            = busy_reg;
`ifdef ROLHAS_TX_TIMEOUT_EN
  assign bus.tx_err          = tx_err_reg;
`else
  assign bus.tx_err          = 1'b0;
`endif

endmodule

// File: tb/tb_rolhas_transfer_tx.sv
// tb_rolhas_transfer_tx
// Self-checking bench for rolhas_transfer_tx. Randomised transfers are
// checked against a transaction-level model: the expected batch is derived
// from plain integer arithmetic and each handshake phase has a fixed
// expected output set. With ROLHAS_TX_TIMEOUT_EN defined the DUT is built
// with TIMEOUT_CYC=8 and the timeout/ERR behaviour is exercised too.
module tb_rolhas_transfer_tx;
  import rolhas_pkg::*;

  localparam int W   = ROLHAS_WIDTH;
  localparam int CAP = ROLHAS_CAPACITY;
  localparam int MB  = ROLHAS_MAX_BATCH;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_err  = 0;

  rolhas_transfer_tx_if #(.WIDTH(W)) bus ();

`ifdef ROLHAS_TX_TIMEOUT_EN
  rolhas_transfer_tx #(
    .WIDTH(W), .CAPACITY(CAP), .MAX_BATCH(MB), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );
`else
  rolhas_transfer_tx #(
    .WIDTH(W), .CAPACITY(CAP), .MAX_BATCH(MB)
  ) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input int req, input int xfer,
                      input int dec, input int busy);
    chk({tag, ".req"},     int'(bus.req), req);
    chk({tag, ".xfer"},    int'(bus.rolhas_transfer), xfer);
    chk({tag, ".sec_dec"}, int'(bus.sec_dec), dec);
    chk({tag, ".busy"},    int'(bus.busy), busy);
    chk({tag, ".tx_err"},  int'(bus.tx_err), exp_err);
  endtask

  // Sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference batch: min(sec, free room, MAX_BATCH) with room floored at 0.
  function automatic int model_batch(input int s, input int p);
    int room;
    int b;
    room = (p >= CAP) ? 0 : CAP - p;
    b = (s < room) ? s : room;
    if (b > MB) b = MB;
    return b;
  endfunction

  // Starts a transfer from IDLE; returns the expected batch (0 = none).
  task automatic start(input int s, input int p, output int b);
    bus.enable = 1'b1; bus.min_r = 1'b1; bus.ack = 1'b0;
    bus.sec_count = W'(s); bus.pri_count = W'(p);
    tick();
    b = 0;
    if (s == 0) begin
      outs("no_start_empty", 0, 0, 0, 0);
      return;
    end
    outs("load", 0, 0, 0, 1);
    tick();
    b = model_batch(s, p);
    if (b == 0) outs("load_zero", 0, 0, 0, 0);
    else        outs("req_rise", 1, b, 0, 1);
    // Counts are only sampled in LOAD; scramble them afterwards.
    bus.sec_count = W'($urandom_range(0, 127));
    bus.pri_count = W'($urandom_range(0, 127));
    $display("xfer start sec=%0d pri=%0d batch=%0d", s, p, b);
  endtask

  task automatic do_xfer(input int s, input int p, input int ack_dly,
                         input int rel_dly, input bit drop_at_ack,
                         input bit drop_in_rel);
    int b;
    start(s, p, b);
    if (b == 0) return;
    repeat (ack_dly) begin
      tick(); outs("req_hold", 1, b, 0, 1);
    end
    bus.ack = 1'b1;
    if (drop_at_ack) bus.enable = 1'b0;
    tick(); outs("ack_commit", 0, b, 1, 1);
    if (drop_in_rel) bus.enable = 1'b0;
    repeat (rel_dly) begin
      tick(); outs("rel_hold", 0, b, 0, 1);
    end
    bus.ack = 1'b0;
    tick(); outs("rel_done", 0, 0, 0, 0);
  endtask

  task automatic do_abort(input int s, input int p, input int dly);
    int b;
    start(s, p, b);
    if (b == 0) return;
    repeat (dly) begin
      tick(); outs("abort_hold", 1, b, 0, 1);
    end
    bus.enable = 1'b0;
    tick(); outs("abort", 0, 0, 0, 0);
  endtask

  initial begin
    int b;
    bus.enable = 1'b0; bus.min_r = 1'b0; bus.ack = 1'b0;
    bus.sec_count = '0; bus.pri_count = '0;
    clr = 1'b0;
    repeat (2) tick();
    outs("reset", 0, 0, 0, 0);
    @(negedge clk); clr = 1'b1;
    tick();
    outs("post_reset_idle", 0, 0, 0, 0);

    // Directed cases.
    do_xfer(40, 3, 2, 1, 1'b0, 1'b0);    // batch 15
    do_xfer(6, 3, 0, 0, 1'b0, 1'b0);     // batch 6
    do_xfer(40, 90, 1, 2, 1'b0, 1'b0);   // batch 9
    do_xfer(40, 99, 0, 0, 1'b0, 1'b0);   // full: no req
    do_xfer(40, 120, 0, 0, 1'b0, 1'b0);  // above capacity: no req
    do_xfer(0, 3, 0, 0, 1'b0, 1'b0);     // empty secondary: no start
    do_abort(40, 3, 2);
    do_xfer(40, 3, 1, 1, 1'b0, 1'b1);    // enable drop in RELEASE
    do_xfer(40, 3, 0, 0, 1'b1, 1'b0);    // ack and enable drop together

    // Stale ack held from before enable keeps the block idle.
    bus.ack = 1'b1; bus.min_r = 1'b1; bus.enable = 1'b1;
    bus.sec_count = W'(40); bus.pri_count = W'(3);
    repeat (3) begin tick(); outs("stale_ack", 0, 0, 0, 0); end
    bus.ack = 1'b0;
    tick(); outs("stale_release_load", 0, 0, 0, 1);
    tick(); outs("stale_release_req", 1, 15, 0, 1);
    bus.ack = 1'b1; tick(); outs("stale_commit", 0, 15, 1, 1);
    bus.ack = 1'b0; tick(); outs("stale_done", 0, 0, 0, 0);

    // Idle gating by enable and min_r.
    bus.enable = 1'b0; bus.min_r = 1'b1;
    repeat (2) begin tick(); outs("idle_disabled", 0, 0, 0, 0); end
    bus.enable = 1'b1; bus.min_r = 1'b0;
    repeat (2) begin tick(); outs("idle_no_min", 0, 0, 0, 0); end

    // Asynchronous reset in the middle of REQ.
    start(40, 3, b);
    #2 clr = 1'b0;
    #1 outs("async_clr", 0, 0, 0, 0);
    @(negedge clk); outs("clr_held", 0, 0, 0, 0);
    bus.enable = 1'b0;
    clr = 1'b1;
    tick(); outs("after_clr", 0, 0, 0, 0);
    do_xfer(20, 50, 1, 1, 1'b0, 1'b0);

`ifdef ROLHAS_TX_TIMEOUT_EN
    // Never acknowledge: 8 cycles in REQ, then ERR with sticky tx_err.
    start(40, 3, b);
    repeat (7) begin tick(); outs("tmo_wait", 1, 15, 0, 1); end
    tick(); exp_err = 1; outs("tmo_err", 0, 0, 0, 1);
    repeat (2) begin tick(); outs("err_hold", 0, 0, 0, 1); end
    bus.enable = 1'b0;
    tick(); outs("err_exit", 0, 0, 0, 0);
    do_xfer(10, 10, 1, 1, 1'b0, 1'b0);   // tx_err remains set
    @(negedge clk); clr = 1'b0;
    #1 exp_err = 0; outs("err_clr", 0, 0, 0, 0);
    @(negedge clk); clr = 1'b1;
    tick();
`endif

    // Randomised transfers against the model.
    for (int i = 0; i < 40; i++) begin
      int s, p, mode;
      s = (($urandom_range(0, 9)) == 0) ? 0 : int'($urandom_range(1, 60));
      p = int'($urandom_range(0, 127));
      mode = int'($urandom_range(0, 9));
      if (mode < 2) begin
        do_abort(($urandom_range(1, 60)), int'($urandom_range(0, 98)),
                 int'($urandom_range(0, 4)));
      end else begin
        do_xfer(s, p, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.min_r = 1'b0;
        tick(); outs("rand_gap", 0, 0, 0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
